// File: rtl/cw_mem_responder.sv
// cw_mem_responder: CW-bus target serving core transactions from a local word memory.
// Decodes the two-word address phase, range/length checks it, then serves read bursts
// (2-cycle beat period, responder drives the bus) or write bursts (master drives the bus).
// A backdoor preload port shares the memory and wins any same-cycle collision.
// Optional feature macro: CW_RESP_WAITSTATE_EN adds i_ws_cnt idle cycles before every ack.
module cw_mem_responder #(
  parameter int                 DATA_W         = 16,
  parameter int                 ADDR_W         = 24,
  parameter int                 MEM_AW         = 10,
  parameter logic [ADDR_W-1:0]  BASE_ADDR      = 24'hFFE000,
  parameter int                 MAX_BURST_LOG2 = 3
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cw_req,
  input  logic              i_cw_dir,
  input  logic [DATA_W-1:0] i_cw_io,
  output logic [DATA_W-1:0] o_cw_io,
  output logic              o_cw_io_oe,
  output logic              o_cw_ack,
  output logic              o_cw_err,
`ifdef CW_RESP_WAITSTATE_EN
  input  logic [3:0]        i_ws_cnt,
`endif
  input  logic              i_ld_we,
  input  logic [MEM_AW-1:0] i_ld_addr,
  input  logic [DATA_W-1:0] i_ld_data,
  output logic              o_busy
);

  localparam int BW = MAX_BURST_LOG2 + 1;

  typedef enum logic [3:0] {
    IDLE, ADDR1, CHECK, RD_TURN, RD_BEAT, RD_GAP, WR_WAIT, WR_ACK, DRAIN
  } state_t;

  state_t              state, state_d;
  logic [BW-1:0]       beat, beat_d;
  logic [7:0]          a_hi;
  logic [15:0]         a_lo;
  logic [2:0]          blog2;
  logic                we;
  logic [ADDR_W-1:0]   addr;
  logic [BW-1:0]       nbeats;
  logic [MEM_AW-1:0]   ptr;
  logic                hit, ok, last_done;
  logic                rd_go, wr_go, rd_phase, ack_state;
  logic                ack, err, ws_done;
  logic [DATA_W-1:0]   rdata;
  logic [DATA_W-1:0]   mem [2**MEM_AW];

  assign addr      = ADDR_W'({a_hi, a_lo});
  assign hit       = addr[ADDR_W-1:MEM_AW] == BASE_ADDR[ADDR_W-1:MEM_AW];
  assign ok        = hit && (int'(blog2) <= MAX_BURST_LOG2);
  assign nbeats    = BW'(1) << blog2;
  assign last_done = (beat == nbeats);
  // Pointer wraps inside the memory rather than leaving the window mid-burst.
  assign ptr       = a_lo[MEM_AW-1:0] + MEM_AW'(beat);
  assign rd_phase  = (state == RD_BEAT) || (state == RD_GAP);
  assign ack_state = (state == CHECK) || (state == RD_BEAT) || (state == WR_ACK);

  // Memory accesses happen on the edge leaving the issuing state; the backdoor
  // strobe blocks them so the CW side simply retries the next cycle.
  assign rd_go = i_cw_req && !i_ld_we &&
                 (((state == RD_TURN) && i_cw_dir) || ((state == RD_GAP) && !last_done));
  assign wr_go = i_cw_req && !i_ld_we && (state == WR_WAIT) && !i_cw_dir;

`ifdef CW_RESP_WAITSTATE_EN
  logic [3:0] ws_q, ws_lim, ws_cnt;
  assign ws_lim  = (state == CHECK) ? i_ws_cnt : ws_q;
  assign ws_done = (ws_cnt == ws_lim);

  // Wait-state counter: counts idle cycles in each ack state, limit captured at CHECK.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ws_q   <= '0;
      ws_cnt <= '0;
    end else begin
      if (state == CHECK) ws_q <= i_ws_cnt;
      if (ack_state && !ws_done && i_cw_req) ws_cnt <= ws_cnt + 4'd1;
      else                                   ws_cnt <= '0;
    end
  end
`else
  assign ws_done = 1'b1;
`endif

  // State and beat counter registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      beat  <= '0;
    end else begin
      state <= state_d;
      beat  <= beat_d;
    end
  end

  // Next-state, beat advance and ack/err decode.
  always_comb begin
    state_d = state;
    beat_d  = beat;
    ack     = 1'b0;
    err     = 1'b0;
    unique case (state)
      IDLE:    if (i_cw_req && !i_cw_dir) state_d = ADDR1;
      ADDR1:   state_d = CHECK;
      CHECK: begin
        beat_d = '0;
        if (ws_done) begin
          if (ok) begin
            ack     = 1'b1;
            state_d = we ? WR_WAIT : RD_TURN;
          end else begin
            err     = 1'b1;
            state_d = DRAIN;
          end
        end
      end
      RD_TURN: if (rd_go) state_d = RD_BEAT;
      RD_BEAT: begin
        if (ws_done) begin
          ack     = 1'b1;
          beat_d  = beat + BW'(1);
          state_d = RD_GAP;
        end
      end
      RD_GAP: begin
        if (last_done)  state_d = DRAIN;
        else if (rd_go) state_d = RD_BEAT;
      end
      WR_WAIT: begin
        if (wr_go) begin
          beat_d  = beat + BW'(1);
          state_d = WR_ACK;
        end
      end
      WR_ACK: begin
        if (ws_done) begin
          ack     = 1'b1;
          state_d = last_done ? DRAIN : WR_WAIT;
        end
      end
      DRAIN:   if (!i_cw_req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Request dropped mid-transaction aborts straight back to IDLE.
    if ((state != IDLE) && !i_cw_req) begin
      state_d = IDLE;
      beat_d  = '0;
    end
  end

  // Address-phase capture: word0 in IDLE, word1 in ADDR1.
  always_ff @(posedge i_clk) begin
    if ((state == IDLE) && i_cw_req && !i_cw_dir) begin
      a_hi  <= i_cw_io[15:8];
      blog2 <= i_cw_io[6:4];
      we    <= i_cw_io[0];
    end
    if (state == ADDR1) a_lo <= i_cw_io[15:0];
  end

  // Single write port shared by backdoor preload (priority) and CW write beats.
  always_ff @(posedge i_clk) begin
    if (i_ld_we)    mem[i_ld_addr] <= i_ld_data;
    else if (wr_go) mem[ptr]       <= i_cw_io;
  end

  // Registered read data, held through the gap cycle.
  always_ff @(posedge i_clk) begin
    if (rd_go) rdata <= mem[ptr];
  end

  assign o_cw_ack   = ack;
  assign o_cw_err   = err;
  assign o_cw_io    = rd_phase ? rdata : '0;
  // Drive enable follows i_cw_dir combinationally so a master turnaround never contends.
  assign o_cw_io_oe = rd_phase && i_cw_dir;
  assign o_busy     = (state != IDLE);

endmodule

// File: tb/tb_cw_mem_responder.sv
// Directed bench for cw_mem_responder: a word-array model of the memory feeds an
// expected-read-data queue, one monitor checks every cycle, driver tasks check timing.
module tb_cw_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0, dir = 1'b0;
  logic [15:0] io = '0;
  logic [15:0] o_io;
  logic        oe, ack, err, busy;
  logic        ld_we = 1'b0;
  logic [9:0]  ld_addr = '0;
  logic [15:0] ld_data = '0;

  int checks = 0;
  int errors = 0;

  logic [15:0] model [1024];
  logic [15:0] exp_q [$];
  logic [15:0] rd_cap [8];

  always #5 clk = ~clk;

  cw_mem_responder dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_cw_req   (req),
    .i_cw_dir   (dir),
    .i_cw_io    (io),
    .o_cw_io    (o_io),
    .o_cw_io_oe (oe),
    .o_cw_ack   (ack),
    .o_cw_err   (err),
`ifdef CW_RESP_WAITSTATE_EN
    .i_ws_cnt   (4'd0),
`endif
    .i_ld_we    (ld_we),
    .i_ld_addr  (ld_addr),
    .i_ld_data  (ld_data),
    .o_busy     (busy)
  );

  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle monitor: exclusivity, no drive while master owns bus, read data vs model.
  always @(negedge clk) begin
    if (rst_n) begin
      chk(!(ack && err), "ack_err_excl", {ack, err}, 32'd0);
      chk(!(oe && !dir), "oe_while_dir0", oe, 32'd0);
      if (ack && oe) begin
        if (exp_q.size() == 0) chk(1'b0, "unexpected_beat", o_io, 32'd0);
        else begin
          logic [15:0] v;
          v = exp_q.pop_front();
          chk(o_io == v, "rd_data", o_io, v);
        end
      end
    end
  end

  task automatic preload(input logic [9:0] a, input logic [15:0] d);
    step();
    ld_we = 1'b1; ld_addr = a; ld_data = d;
    model[a] = d;
    step();
    ld_we = 1'b0;
  endtask

  task automatic addr_phase(input logic [15:0] w0, input logic [15:0] w1, input bit exp_err);
    step(); req = 1'b1; dir = 1'b0; io = w0;
    @(negedge clk); chk(!ack && !err, "addr_c0_quiet", {ack, err}, 32'd0);
    step(); io = w1;
    @(negedge clk); chk(!ack && !err, "addr_c1_quiet", {ack, err}, 32'd0);
    step(); io = '0;
    @(negedge clk);
    chk(ack == !exp_err, "addr_ack_c2", ack, !exp_err);
    chk(err == exp_err,  "addr_err_c2", err, exp_err);
  endtask

  task automatic finish_txn();
    step(); req = 1'b0; dir = 1'b0; io = '0;
    @(negedge clk);
    step();
    @(negedge clk);
    chk(busy == 1'b0, "idle_after_req_low", busy, 32'd0);
    chk(ack == 1'b0,  "no_ack_idle", ack, 32'd0);
  endtask

  // kill: 0 none, 1 drop req after beat kbeat, 2 pulse reset after beat kbeat.
  task automatic rd_txn(input logic [15:0] w0, input logic [15:0] w1, input int nb,
                        input int coll, input int ddrop, input int kill, input int kbeat);
    int n, last, b;
    bit ld_pend, dd_pend, k_pend;
    logic [9:0] a;
    for (int i = 0; i < nb; i++) begin
      a = w1[9:0] + 10'(i);
      exp_q.push_back(model[a]);
    end
    addr_phase(w0, w1, 1'b0);
    step(); dir = 1'b1;
    n = 3; last = 2; b = 0; ld_pend = 0; dd_pend = 0; k_pend = 0;
    while (b < nb && n < 48) begin
      @(negedge clk);
      if (!dir) chk(oe == 1'b0, "oe_gate_dir0", oe, 32'd0);
      if (ack) begin
        chk((n - last) == ((b == coll) ? 3 : 2), "beat_gap", n - last, (b == coll) ? 3 : 2);
        rd_cap[b] = o_io;
        ld_pend = (b + 1 == coll);
        dd_pend = (b == ddrop);
        k_pend  = (kill != 0) && (b == kbeat);
        last = n;
        b++;
      end
      step(); n++;
      if (k_pend) break;
      ld_we = ld_pend;
      if (ld_pend) model[ld_addr] = ld_data;
      ld_pend = 0;
      dir = !dd_pend;
      dd_pend = 0;
    end
    ld_we = 1'b0;
    if (k_pend) begin
      if (kill == 1) begin
        req = 1'b0;
        @(negedge clk);
        step();
        @(negedge clk);
      end else begin
        rst_n = 1'b0;
        @(negedge clk);
      end
      chk(ack == 1'b0,  "kill_ack", ack, 32'd0);
      chk(oe == 1'b0,   "kill_oe", oe, 32'd0);
      chk(err == 1'b0,  "kill_err", err, 32'd0);
      chk(busy == 1'b0, "kill_busy", busy, 32'd0);
      if (kill == 2) begin
        step(); rst_n = 1'b1;
      end
      req = 1'b0; dir = 1'b0;
      exp_q.delete();
      return;
    end
    chk(b == nb, "beat_count", b, nb);
    chk(exp_q.size() == 0, "exp_q_drained", exp_q.size(), 32'd0);
    finish_txn();
  endtask

  task automatic wr2_txn(input logic [15:0] w0, input logic [15:0] w1,
                         input logic [15:0] d0, input logic [15:0] d1);
    logic [15:0] d [2];
    logic [9:0]  a;
    d[0] = d0; d[1] = d1;
    addr_phase(w0, w1, 1'b0);
    for (int b = 0; b < 2; b++) begin
      step(); io = d[b];
      @(negedge clk); chk(ack == 1'b0, "wr_wait_noack", ack, 32'd0);
      step();
      @(negedge clk); chk(ack == 1'b1, "wr_beat_ack", ack, 32'd1);
      a = w1[9:0] + 10'(b);
      model[a] = d[b];
    end
    finish_txn();
  endtask

  task automatic err_txn(input logic [15:0] w0, input logic [15:0] w1);
    addr_phase(w0, w1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(); io = 16'hdead;
      @(negedge clk);
      chk(!ack && !err, "drain_quiet", {ack, err}, 32'd0);
      chk(busy == 1'b1, "drain_busy", busy, 32'd1);
    end
    finish_txn();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] pre0 [8];
    pre0 = '{16'h000e, 16'h0100, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk(ack == 0,  "rst_ack",  ack, 32'd0);
    chk(err == 0,  "rst_err",  err, 32'd0);
    chk(oe == 0,   "rst_oe",   oe, 32'd0);
    chk(o_io == 0, "rst_io",   o_io, 32'd0);
    chk(busy == 0, "rst_busy", busy, 32'd0);
    step(); rst_n = 1'b1;

    for (int i = 0; i < 8; i++) preload(10'(i), pre0[i]);
    preload(10'h3fe, 16'haaaa);
    preload(10'h3ff, 16'hbbbb);
    preload(10'h080, 16'h1234);
    preload(10'h102, 16'h0);
    preload(10'h103, 16'h0);
    preload(10'h200, 16'h0);

    // Basic 4-beat read from the window base.
    rd_txn(16'hff20, 16'he000, 4, -1, -1, 0, 0);
    chk(rd_cap[0] == 16'h000e, "lit_rd0", rd_cap[0], 16'h000e);
    chk(rd_cap[1] == 16'h0100, "lit_rd1", rd_cap[1], 16'h0100);

    // 2-beat write and readback.
    wr2_txn(16'hff11, 16'he102, 16'hf8e2, 16'ha0a0);
    rd_txn(16'hff10, 16'he102, 2, -1, -1, 0, 0);
    chk(rd_cap[0] == 16'hf8e2, "lit_wrbk0", rd_cap[0], 16'hf8e2);
    chk(rd_cap[1] == 16'ha0a0, "lit_wrbk1", rd_cap[1], 16'ha0a0);

    // Out-of-window write leaves memory untouched; over-long burst is rejected.
    err_txn(16'h1001, 16'h0080);
    rd_txn(16'hff00, 16'he080, 1, -1, -1, 0, 0);
    chk(rd_cap[0] == 16'h1234, "lit_oow_untouched", rd_cap[0], 16'h1234);
    err_txn(16'hff40, 16'he000);

    // Wrapping burst with a master turnaround glitch in the first gap.
    rd_txn(16'hff20, 16'he3fe, 4, -1, 0, 0, 0);
    chk(rd_cap[0] == 16'haaaa, "lit_wrap0", rd_cap[0], 16'haaaa);
    chk(rd_cap[2] == 16'h000e, "lit_wrap2", rd_cap[2], 16'h000e);
    chk(rd_cap[3] == 16'h0100, "lit_wrap3", rd_cap[3], 16'h0100);

    // Backdoor collision before beat 2 defers that ack by one cycle.
    ld_addr = 10'h200; ld_data = 16'h5a5a;
    rd_txn(16'hff20, 16'he000, 4, 2, -1, 0, 0);
    chk(rd_cap[2] == 16'h0000, "lit_coll_data", rd_cap[2], 16'h0000);
    rd_txn(16'hff00, 16'he200, 1, -1, -1, 0, 0);
    chk(rd_cap[0] == 16'h5a5a, "lit_backdoor", rd_cap[0], 16'h5a5a);

    // Request drop mid 8-beat burst, then a fresh request.
    rd_txn(16'hff30, 16'he000, 8, -1, -1, 1, 1);
    rd_txn(16'hff00, 16'he001, 1, -1, -1, 0, 0);
    chk(rd_cap[0] == 16'h0100, "lit_after_abort", rd_cap[0], 16'h0100);

    // Reset pulse mid-burst, then a fresh request.
    rd_txn(16'hff30, 16'he000, 8, -1, -1, 2, 2);
    rd_txn(16'hff00, 16'he000, 1, -1, -1, 0, 0);
    chk(rd_cap[0] == 16'h000e, "lit_after_reset", rd_cap[0], 16'h000e);

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
